// File: rtl/aud_pkg.sv
// Shared definitions for the audio I2S transmit path.
//   AUD_WIDTH : default sample width in bits
//   aud_ch_e  : I2S slot identifier (left/right)
//   sat_inc   : saturating increment for status counters of up to 32 bits
package aud_pkg;

    localparam int AUD_WIDTH = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } aud_ch_e;

    // Counters narrower than 32 bits are zero-extended on the way in and
    // truncated by the caller; the all-ones value for 'width' is the ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/aud_sample_fifo.sv
// Small synchronous sample FIFO between the effect chain and the serialiser.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO (takes priority over push/pop)
//   push       : write request; accepted when not full, or when full and a pop
//                lands in the same cycle
//   pop        : read request; ignored when empty (no write-through bypass)
//   wr_data    : sample to write
//   rd_data    : head of the FIFO (valid when not empty)
//   full, empty: occupancy flags
//   level      : number of occupied entries
module aud_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/aud_i2s_tx.sv
// I2S transmitter for the WM8731 DAC path. One mono sample per frame is
// buffered and sent MSB-first on both the left and right slots, one BCLK
// after each slot-start edge of the codec-mastered word clock.
// Ports:
//   i_rst_n        : asynchronous active-low reset
//   i_AUD_BCLK     : codec bit clock, all logic on its rising edge
//   i_AUD_DACLRCK  : codec word clock (low = left, high = right)
//   i_en           : transmitter enable (low flushes FIFO and sends zeros)
//   i_mute         : zero the next frame, sampled at left-slot start
//   i_data/i_valid : sample and its 1-cycle strobe
//   o_AUD_DACDAT   : serial data to the codec
//   o_frame_start  : 1-cycle pulse in the first bit cycle of a left slot
//   o_fifo_level   : FIFO occupancy
//   o_underrun_cnt : saturating count of frames with no fresh sample
//   o_overrun_cnt  : saturating count of samples dropped on a full FIFO
module aud_i2s_tx
    import aud_pkg::*;
#(
    parameter int WIDTH            = AUD_WIDTH,
    parameter int FIFO_DEPTH       = 2,
    parameter bit HOLD_ON_UNDERRUN = 1'b1,
    parameter int CNT_W            = 8
) (
    input  logic                          i_rst_n,
    input  logic                          i_AUD_BCLK,
    input  logic                          i_AUD_DACLRCK,
    input  logic                          i_en,
    input  logic                          i_mute,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_valid,
    output logic                          o_AUD_DACDAT,
    output logic                          o_frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [CNT_W-1:0]              o_underrun_cnt,
    output logic [CNT_W-1:0]              o_overrun_cnt
);

    localparam int BC_W = $clog2(WIDTH + 1);

    logic             lrck_d;
    logic             ls;
    logic             rs;
    logic             push_req;
    logic             pop_req;
    logic             pop_ok;
    logic             overrun;
    logic             underrun;
    logic             accepted;
    logic             armed;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0] frame_word;
    logic [WIDTH-1:0] last_word;
    logic [WIDTH-1:0] left_word;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    aud_ch_e          slot_ch;

    assign ls = lrck_d & ~i_AUD_DACLRCK;
    assign rs = ~lrck_d & i_AUD_DACLRCK;

    assign push_req = i_valid & i_en;
    assign pop_req  = ls & i_en;
    assign pop_ok   = pop_req & ~fifo_empty;
    // Full implies non-empty, so any pop in the same cycle frees a slot.
    assign overrun  = push_req & fifo_full & ~pop_req;
    assign accepted = push_req & ~overrun;
    assign underrun = pop_req & fifo_empty & armed;

    aud_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_AUD_BCLK),
        .rst_n   (i_rst_n),
        .flush   (~i_en),
        .push    (push_req),
        .pop     (pop_req),
        .wr_data (i_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    always_comb begin
        left_word = '0;
        load_word = '0;
        slot_ch   = ls ? CH_LEFT : CH_RIGHT;

        if (i_en && !i_mute) begin
            if (!fifo_empty)           left_word = fifo_head;
            else if (HOLD_ON_UNDERRUN) left_word = last_word;
        end

        if (i_en) begin
            load_word = (slot_ch == CH_LEFT) ? left_word : frame_word;
        end
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d        <= 1'b0;
            o_frame_start <= 1'b0;
            frame_word    <= '0;
            last_word     <= '0;
            armed         <= 1'b0;
            shreg         <= '0;
            bit_cnt       <= '0;
        end else begin
            lrck_d        <= i_AUD_DACLRCK;
            o_frame_start <= ls;

            if (ls)     frame_word <= left_word;
            if (pop_ok) last_word  <= fifo_head;

            if (!i_en)         armed <= 1'b0;
            else if (accepted) armed <= 1'b1;

            // A slot start always reloads, discarding any bits left over
            // from a short slot.
            if (ls || rs) begin
                shreg   <= load_word;
                bit_cnt <= BC_W'(WIDTH);
            end else if (bit_cnt != '0) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt - BC_W'(1);
            end
        end
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_underrun_cnt <= '0;
            o_overrun_cnt  <= '0;
        end else begin
            if (underrun) o_underrun_cnt <= CNT_W'(sat_inc(32'(o_underrun_cnt), CNT_W));
            if (overrun)  o_overrun_cnt  <= CNT_W'(sat_inc(32'(o_overrun_cnt), CNT_W));
        end
    end

    // Gated by bit_cnt so the line idles low after the LSB and drops
    // immediately on reset.
    assign o_AUD_DACDAT = (bit_cnt != '0) && shreg[WIDTH-1];

endmodule
